// File: rtl/azimuth_pkg.sv
// Shared azimuth types and helpers: capture FSM states, default frame size, counter width.
package azimuth_pkg;

  localparam int unsigned SIZE_DEFAULT = 3200;

  typedef enum logic [1:0] {
    WAIT_TRIG = 2'd0,
    CAPTURE   = 2'd1,
    HOLD      = 2'd2
  } cap_state_e;

  // Counter must be able to hold the value n itself, not just n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/azimuth_signal_capture_if.sv
// Frame hand-off bus of the azimuth capture block: parallel word with valid/ready.
interface azimuth_signal_capture_if
  import azimuth_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEFAULT
);
  logic [SIZE-1:0] DATA;
  logic            DATA_VALID;
  logic            DATA_READY;

  modport master (output DATA, output DATA_VALID, input DATA_READY);
  modport slave  (input DATA, input DATA_VALID, output DATA_READY);
endinterface

// File: rtl/azimuth_sig_sync.sv
// Parameterised N-flop synchronizer / delay line with synchronous active-high reset.
module azimuth_sig_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/azimuth_signal_capture.sv
// Serial azimuth capture: TRIG-framed sampling of SIG_IN on CLK_PE into a SIZE-bit word.
// Optional input synchronizer enabled by `define AZIMUTH_CAPTURE_SIG_SYNC_EN.
module azimuth_signal_capture
  import azimuth_pkg::*;
#(
  parameter int unsigned SIZE  = SIZE_DEFAULT,
  parameter int unsigned CNT_W = cnt_width(SIZE)
) (
  input  logic                      SYS_CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      TRIG,
  input  logic                      CLK_PE,
  input  logic                      SIG_IN,
  azimuth_signal_capture_if.master  dout,
  output logic [CNT_W-1:0]          BIT_CNT,
  output logic                      SHORT_FRAME,
  output logic                      OVERRUN
);

  logic trig;
  logic clk_pe;
  logic sig;

`ifdef AZIMUTH_CAPTURE_SIG_SYNC_EN
  // Strobes ride the same two flops as SIG_IN so sample alignment is preserved.
  logic [2:0] sync_q;

  azimuth_sig_sync #(
    .WIDTH  (3),
    .STAGES (2)
  ) u_sig_sync (
    .CLK (SYS_CLK),
    .RST (RST),
    .d   ({TRIG, CLK_PE, SIG_IN}),
    .q   (sync_q)
  );

  assign {trig, clk_pe, sig} = sync_q;
`else
  assign trig   = TRIG;
  assign clk_pe = CLK_PE;
  assign sig    = SIG_IN;
`endif

  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIZE-1:0]   shreg_q, shreg_d;
  logic [SIZE-1:0]   data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              short_q, short_d;
  logic [SIZE-1:0]   frame_next;

  // Shift register with the current sample inserted at index cnt_q.
  always_comb begin
    frame_next = shreg_q;
    for (int unsigned k = 0; k < SIZE; k++) begin
      if (CNT_W'(k) == cnt_q) frame_next[k] = sig;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    short_d   = 1'b0;

    if (valid_q && dout.DATA_READY) valid_d = 1'b0;

    if (!EN) begin
      state_d = WAIT_TRIG;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        WAIT_TRIG: begin
          if (trig) begin
            state_d = CAPTURE;
            cnt_d   = '0;
          end
        end
        CAPTURE: begin
          if (trig) begin
            // Coincident CLK_PE is dropped; a partial frame is flagged and discarded.
            cnt_d = '0;
            if (cnt_q != '0) short_d = 1'b1;
          end else if (clk_pe) begin
            shreg_d = frame_next;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SIZE - 1)) begin
              state_d = HOLD;
              if (!valid_q || dout.DATA_READY) begin
                data_d  = frame_next;
                valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (trig) begin
            state_d = CAPTURE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = WAIT_TRIG;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q   <= WAIT_TRIG;
      cnt_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      short_q   <= short_d;
    end
  end

  assign dout.DATA       = data_q;
  assign dout.DATA_VALID = valid_q;
  assign BIT_CNT         = cnt_q;
  assign SHORT_FRAME     = short_q;
  assign OVERRUN         = overrun_q;

endmodule

// File: tb/tb_azimuth_signal_capture.sv
// Directed self-checking bench for azimuth_signal_capture at SIZE=16.
module tb_azimuth_signal_capture;

  localparam int unsigned SZ  = 16;
  localparam int unsigned CW  = $clog2(SZ + 1);
`ifdef AZIMUTH_CAPTURE_SIG_SYNC_EN
  localparam int          LAT = 3;
`else
  localparam int          LAT = 1;
`endif

  logic          SYS_CLK;
  logic          RST;
  logic          EN;
  logic          TRIG;
  logic          CLK_PE;
  logic          SIG_IN;
  logic [CW-1:0] BIT_CNT;
  logic          SHORT_FRAME;
  logic          OVERRUN;

  azimuth_signal_capture_if #(.SIZE(SZ)) dout_if ();

  azimuth_signal_capture #(.SIZE(SZ)) dut (
    .SYS_CLK     (SYS_CLK),
    .RST         (RST),
    .EN          (EN),
    .TRIG        (TRIG),
    .CLK_PE      (CLK_PE),
    .SIG_IN      (SIG_IN),
    .dout        (dout_if),
    .BIT_CNT     (BIT_CNT),
    .SHORT_FRAME (SHORT_FRAME),
    .OVERRUN     (OVERRUN)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int short_cnt = 0;
  int lat;

  always @(negedge SYS_CLK) if (SHORT_FRAME === 1'b1) short_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic settle();
    repeat (3) tick();
  endtask

  task automatic pulse_trig();
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    tick();
  endtask

  task automatic send_samples(input int n, input logic [SZ-1:0] w);
    logic [SZ-1:0] s;
    s = w;
    for (int k = 0; k < n; k++) begin
      CLK_PE = 1'b1;
      SIG_IN = s[0];
      s      = s >> 1;
      tick();
      CLK_PE = 1'b0;
      tick();
    end
  endtask

  // Full frame; rdy raises DATA_READY exactly in the cycle the frame is loaded.
  task automatic send_frame(input logic [SZ-1:0] w, input bit rdy, output int lat_o);
    logic [SZ-1:0] s;
    s = w >> (SZ - 1);
    send_samples(SZ - 1, w);
    CLK_PE = 1'b1;
    SIG_IN = s[0];
    dout_if.DATA_READY = rdy && (LAT == 1);
    lat_o = 0;
    for (int i = 1; i <= LAT + 2; i++) begin
      tick();
      CLK_PE = 1'b0;
      dout_if.DATA_READY = rdy && (i == LAT - 1);
      if (lat_o == 0 && dout_if.DATA_VALID === 1'b1) lat_o = i;
    end
    dout_if.DATA_READY = 1'b0;
  endtask

  task automatic accept();
    dout_if.DATA_READY = 1'b1;
    tick();
    dout_if.DATA_READY = 1'b0;
  endtask

  initial begin
    RST = 1'b1; EN = 1'b1; TRIG = 1'b0; CLK_PE = 1'b0; SIG_IN = 1'b0;
    dout_if.DATA_READY = 1'b0;
    tick(); tick();
    RST = 1'b0;
    check("rst_data",    64'(dout_if.DATA), 64'h0);
    check("rst_valid",   64'(dout_if.DATA_VALID), 64'h0);
    check("rst_bitcnt",  64'(BIT_CNT), 64'h0);
    check("rst_short",   64'(SHORT_FRAME), 64'h0);
    check("rst_overrun", 64'(OVERRUN), 64'h0);

    // Partial frame aborted by TRIG, then a clean frame.
    pulse_trig();
    send_samples(7, 16'hFFFF);
    settle();
    check("partial_bitcnt", 64'(BIT_CNT), 64'd7);
    pulse_trig();
    send_frame(16'hA5C3, 1'b0, lat);
    settle();
    check("a5c3_latency", 64'(lat), 64'(LAT));
    check("a5c3_short",   64'(short_cnt), 64'd1);
    check("a5c3_data",    64'(dout_if.DATA), 64'hA5C3);
    check("a5c3_valid",   64'(dout_if.DATA_VALID), 64'h1);
    check("a5c3_overrun", 64'(OVERRUN), 64'h0);
    check("a5c3_bitcnt",  64'(BIT_CNT), 64'd16);

    // CLK_PE ignored in HOLD.
    send_samples(1, 16'h0000);
    settle();
    check("hold_bitcnt", 64'(BIT_CNT), 64'd16);
    check("hold_data",   64'(dout_if.DATA), 64'hA5C3);

    accept();
    check("accept_valid", 64'(dout_if.DATA_VALID), 64'h0);

    // TRIG coincident with CLK_PE: sample dropped.
    TRIG = 1'b1; CLK_PE = 1'b1; SIG_IN = 1'b1;
    tick();
    TRIG = 1'b0; CLK_PE = 1'b0; SIG_IN = 1'b0;
    settle();
    check("coinc_bitcnt", 64'(BIT_CNT), 64'd0);
    send_frame(16'h5A5A, 1'b0, lat);
    settle();
    check("coinc_latency", 64'(lat), 64'(LAT));
    check("coinc_data",    64'(dout_if.DATA), 64'h5A5A);
    check("coinc_short",   64'(short_cnt), 64'd1);

    // Overrun: second frame dropped while the first is unconsumed.
    accept();
    pulse_trig();
    send_frame(16'h1234, 1'b0, lat);
    pulse_trig();
    send_frame(16'hBEEF, 1'b0, lat);
    settle();
    check("ovr_data",    64'(dout_if.DATA), 64'h1234);
    check("ovr_overrun", 64'(OVERRUN), 64'h1);
    check("ovr_valid",   64'(dout_if.DATA_VALID), 64'h1);
    accept();
    check("ovr_accept_valid", 64'(dout_if.DATA_VALID), 64'h0);
    check("ovr_accept_data",  64'(dout_if.DATA), 64'h1234);

    // Accept and load in the same cycle: load wins.
    pulse_trig();
    send_frame(16'h0F0F, 1'b0, lat);
    pulse_trig();
    send_frame(16'h3C3C, 1'b1, lat);
    settle();
    check("simul_data",  64'(dout_if.DATA), 64'h3C3C);
    check("simul_valid", 64'(dout_if.DATA_VALID), 64'h1);

    // EN drop mid-frame.
    pulse_trig();
    send_samples(9, 16'h01FF);
    settle();
    check("en_bitcnt9", 64'(BIT_CNT), 64'd9);
    EN = 1'b0;
    tick();
    check("en_bitcnt0", 64'(BIT_CNT), 64'd0);
    EN = 1'b1;
    send_samples(3, 16'h0007);
    settle();
    check("en_wait_bitcnt", 64'(BIT_CNT), 64'd0);
    check("en_data",        64'(dout_if.DATA), 64'h3C3C);
    check("en_valid",       64'(dout_if.DATA_VALID), 64'h1);
    check("en_overrun",     64'(OVERRUN), 64'h1);
    check("en_short",       64'(short_cnt), 64'd1);

    // RST mid-frame clears everything including sticky OVERRUN.
    pulse_trig();
    send_samples(5, 16'h001F);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst2_data",    64'(dout_if.DATA), 64'h0);
    check("rst2_valid",   64'(dout_if.DATA_VALID), 64'h0);
    check("rst2_bitcnt",  64'(BIT_CNT), 64'h0);
    check("rst2_short",   64'(SHORT_FRAME), 64'h0);
    check("rst2_overrun", 64'(OVERRUN), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
